// File: rtl/cmp_cal_pkg.sv
// Shared widths, FSM encoding and the one-LSB stepping helper for the
// comparator trim driver.
package cmp_cal_pkg;

    localparam int TRIM_W  = 5;
    localparam int THERM_W = 31;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Moves a code one LSB toward its target; equal codes are returned as-is,
    // so the result can never leave the range spanned by cur and tgt.
    function automatic logic [TRIM_W-1:0] step_toward(input logic [TRIM_W-1:0] cur,
                                                      input logic [TRIM_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + 5'd1;
        end else if (cur > tgt) begin
            return cur - 5'd1;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/therm_dec5.sv
// Purely combinational 5-bit binary to 31-bit thermometer decoder:
// bit i is set when i is below the code.
module therm_dec5
    import cmp_cal_pkg::*;
(
    input  logic [TRIM_W-1:0]  i_code,
    output logic [THERM_W-1:0] o_therm
);

    always_comb begin
        o_therm = '0;
        for (int i = 0; i < THERM_W; i++) begin
            o_therm[i] = (i < int'(i_code));
        end
    end

endmodule

// File: rtl/cmp_trim_driver.sv
// Comparator trim driver: walks the left/right trim codes one LSB at a time
// toward a loaded target, never letting both sides be nonzero at once.
module cmp_trim_driver
    import cmp_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int STEP_CYCLES   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [TRIM_W-1:0]  b_left,
    input  logic [TRIM_W-1:0]  b_right,
    output logic               ready,
    output logic               settled,
    output logic               fault,
    output logic [TRIM_W-1:0]  cur_left,
    output logic [TRIM_W-1:0]  cur_right,
    output logic [THERM_W-1:0] therm_left,
    output logic [THERM_W-1:0] therm_right,
    output logic [1:0]         dbg_state
);

    // Handshake: a load is accepted on a rising edge only when ready was high
    // in the cycle before it (IDLE and enabled); otherwise it is dropped.

    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            r_state;
    logic [TRIM_W-1:0] r_tgt_left;
    logic [TRIM_W-1:0] r_tgt_right;
    logic [TRIM_W-1:0] r_cur_left;
    logic [TRIM_W-1:0] r_cur_right;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;
    logic              r_settled;

    state_t            w_state_nxt;
    logic [TRIM_W-1:0] w_tgt_left_nxt;
    logic [TRIM_W-1:0] w_tgt_right_nxt;
    logic [TRIM_W-1:0] w_cur_left_nxt;
    logic [TRIM_W-1:0] w_cur_right_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_fault_nxt;
    logic              w_settled_nxt;
    logic [TRIM_W-1:0] w_step_left;
    logic [TRIM_W-1:0] w_step_right;
    logic              w_ready;

    assign w_ready = (r_state == IDLE) && en;

    // One-LSB move: the opposite side is drained to zero before the target
    // side is touched, which keeps the two codes mutually exclusive.
    always_comb begin
        w_step_left  = r_cur_left;
        w_step_right = r_cur_right;
        if (r_tgt_left != '0) begin
            if (r_cur_right != '0) begin
                w_step_right = r_cur_right - 5'd1;
            end else begin
                w_step_left = step_toward(r_cur_left, r_tgt_left);
            end
        end else begin
            if (r_cur_left != '0) begin
                w_step_left = r_cur_left - 5'd1;
            end else begin
                w_step_right = step_toward(r_cur_right, r_tgt_right);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tgt_left_nxt  = r_tgt_left;
        w_tgt_right_nxt = r_tgt_right;
        w_cur_left_nxt  = r_cur_left;
        w_cur_right_nxt = r_cur_right;
        w_cnt_nxt       = r_cnt;
        w_fault_nxt     = r_fault;
        w_settled_nxt   = 1'b0;

        if (!en) begin
            w_state_nxt     = IDLE;
            w_tgt_left_nxt  = '0;
            w_tgt_right_nxt = '0;
            w_cur_left_nxt  = '0;
            w_cur_right_nxt = '0;
            w_cnt_nxt       = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        if ((b_left != '0) && (b_right != '0)) begin
                            w_fault_nxt = 1'b1;
                        end else begin
                            w_fault_nxt     = 1'b0;
                            w_tgt_left_nxt  = b_left;
                            w_tgt_right_nxt = b_right;
                            w_cnt_nxt       = '0;
                            if ((b_left == r_cur_left) && (b_right == r_cur_right)) begin
                                w_state_nxt = SETTLE;
                            end else begin
                                w_state_nxt = STEP;
                            end
                        end
                    end
                end
                STEP: begin
                    if (r_cnt == STEP_LAST) begin
                        w_cnt_nxt       = '0;
                        w_cur_left_nxt  = w_step_left;
                        w_cur_right_nxt = w_step_right;
                        if ((w_step_left == r_tgt_left) && (w_step_right == r_tgt_right)) begin
                            w_state_nxt = SETTLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_cnt_nxt     = '0;
                        w_state_nxt   = IDLE;
                        w_settled_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tgt_left  <= '0;
            r_tgt_right <= '0;
            r_cur_left  <= '0;
            r_cur_right <= '0;
            r_cnt       <= '0;
            r_fault     <= 1'b0;
            r_settled   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tgt_left  <= w_tgt_left_nxt;
            r_tgt_right <= w_tgt_right_nxt;
            r_cur_left  <= w_cur_left_nxt;
            r_cur_right <= w_cur_right_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fault     <= w_fault_nxt;
            r_settled   <= w_settled_nxt;
        end
    end

    therm_dec5 u_therm_left (
        .i_code  (r_cur_left),
        .o_therm (therm_left)
    );

    therm_dec5 u_therm_right (
        .i_code  (r_cur_right),
        .o_therm (therm_right)
    );

    assign ready     = w_ready;
    assign settled   = r_settled;
    assign fault     = r_fault;
    assign cur_left  = r_cur_left;
    assign cur_right = r_cur_right;
    assign dbg_state = r_state;

endmodule

// File: doc/cmp_trim_driver.md
CMP_TRIM_DRIVER -- requirements
Module: cmp_trim_driver

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: idle cycles after the final trim step before `settled` is reported (range 1..255).
REQ-002 SHALL have parameter STEP_CYCLES, default 1: clock cycles between successive 1-LSB trim steps (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: driver enable; low forces zero trim.
REQ-006 SHALL have port load, input, 1 bit: request strobe, sampled on the rising edge.
REQ-007 SHALL have port b_left, input, 5 bits: requested left trim code, captured on an accepted load.
REQ-008 SHALL have port b_right, input, 5 bits: requested right trim code, captured on an accepted load.
REQ-009 SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-010 SHALL have port settled, output, 1 bit: one-cycle pulse when the target is applied and settled.
REQ-011 SHALL have port fault, output, 1 bit: sticky flag marking a rejected request with both codes nonzero.
REQ-012 SHALL have port cur_left, output, 5 bits: currently applied left code.
REQ-013 SHALL have port cur_right, output, 5 bits: currently applied right code.
REQ-014 SHALL have port therm_left, output, 31 bits: thermometer of cur_left.
REQ-015 SHALL have port therm_right, output, 31 bits: thermometer of cur_right.

Function
REQ-016 SHALL implement states IDLE, STEP and SETTLE; ready = (state==IDLE) && en.
REQ-017 SHALL accept a load only when ready is high; a load while ready is low is ignored without side effects.
REQ-018 SHALL, on an accepted load with b_left!=0 && b_right!=0, set fault, leave the targets and cur_* unchanged, and stay in IDLE.
REQ-019 SHALL, on an accepted valid load, capture the targets, clear fault, and enter STEP (or SETTLE directly if the targets already equal cur_*).
REQ-020 SHALL, in STEP, change exactly one code by exactly 1 LSB every STEP_CYCLES edges; the first change occurs STEP_CYCLES edges after the accept edge.
REQ-021 SHALL step order: if the opposite side is nonzero, decrement it to 0 first, then step the target side toward its target; cur_left and cur_right SHALL never be nonzero simultaneously.
REQ-022 SHALL enter SETTLE on the edge that applies the final step, count SETTLE_CYCLES edges, then return to IDLE and assert settled for exactly one cycle, with ready high in that same cycle.
REQ-023 SHALL drive therm_x[i] = (i < cur_x) for i = 0..30, with no latency relative to cur_x; 5'd31 gives all ones.
REQ-024 SHALL, while en is low, on every edge clear cur_* and the targets to 0, return to IDLE, and hold ready and settled low; fault is held.
REQ-025 SHALL, if en falls mid-STEP or mid-SETTLE, abort with no settled pulse; when en rises again, the block is in IDLE with zero codes.
REQ-026 SHALL never wrap the codes: steps saturate at 0 and 31 by construction, and no overflow path exists.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously force: state IDLE, cur_left = cur_right = 0, targets 0, all therm bits 0, fault 0, settled 0, and all timers 0.
REQ-028 SHALL drive ready = en during reset release; a load on the first edge after release SHALL be accepted.

Structure
REQ-029 SHALL place TRIM_W=5, THERM_W=31 and the state enum (IDLE, STEP, SETTLE) in shared package cmp_cal_pkg.
REQ-030 SHALL instantiate the 5-to-31 thermometer decoder twice as sub-module therm_dec5, which is purely combinational.

Verification
REQ-031 SHALL check: reset, en=1, load with b_left=5, b_right=0 (defaults) -> cur_left reads 1..5 on edges E1..E5 after accept edge E0, settled pulses at E9, therm_left=31'h1F.
REQ-032 SHALL check: from cur_left=3, load with b_right=2 -> cur_left 2,1,0, then cur_right 1,2; never both nonzero; settled 4 edges after cur_right=2.
REQ-033 SHALL check: load with b_left=4, b_right=7 -> fault=1, cur_* unchanged, ready stays high; then a valid load b_left=1 -> fault clears.
REQ-034 SHALL check: load during STEP (ready=0) -> ignored, and the original target is reached unchanged.
REQ-035 SHALL check: en dropped mid-STEP at cur_right=10 -> next edge cur_right=0, therm_right=0, no settled; en restored -> ready=1.
REQ-036 SHALL check: STEP_CYCLES=3 with target b_left=31 -> steps every 3 edges, therm_left all ones; rst_n asserted mid-SETTLE -> all outputs 0 immediately.
